decode_stage: RTL and testbench

- Registered, handshaked RV32 instruction-decode pipeline stage.
- Successor to the combinational decoder: adds a 2-entry skid buffer (valid/ready both sides) and flush.
- Parametrised enables for Zicsr, M-extension decode and misalignment checking.
- Sits between the fetch/IF register and the execute stage.
- Misalignment and store-request are resolved on the output side, in the same cycle the execute stage presents the adder LSBs.

---
 rtl/decode_pkg.sv | 61 ++++++
 rtl/decode_stage_if.sv | 49 ++++
 rtl/decode_logic.sv | 77 +++++++
 rtl/decode_stage.sv | 101 ++++++++++
 tb/tb_decode_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared decode constants and the decoded-bundle type.
// Pure declarations; no latency or flow control.
package decode_pkg;

   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Writeback-mux and immediate-type codes as produced by the bit equations.
   localparam logic [2:0] WB_ALU   = 3'b000;
   localparam logic [2:0] WB_LOAD  = 3'b001;
   localparam logic [2:0] WB_LUI   = 3'b010;
   localparam logic [2:0] WB_AUIPC = 3'b011;
   localparam logic [2:0] WB_CSR   = 3'b100;
   localparam logic [2:0] WB_PC4   = 3'b101;

   localparam logic [2:0] IMM_R   = 3'b000;
   localparam logic [2:0] IMM_I   = 3'b001;
   localparam logic [2:0] IMM_S   = 3'b010;
   localparam logic [2:0] IMM_B   = 3'b011;
   localparam logic [2:0] IMM_U   = 3'b100;
   localparam logic [2:0] IMM_J   = 3'b101;
   localparam logic [2:0] IMM_CSR = 3'b110;

   typedef struct packed {
      logic [3:0] alu_opcode;
      logic [2:0] imm_type;
      logic [2:0] wb_mux_sel;
      logic [2:0] csr_op;
      logic [2:0] muldiv_op;
      logic [1:0] load_size;
      logic       load_unsigned;
      logic       alu_src;
      logic       iadder_src;
      logic       rf_wr_en;
      logic       csr_wr_en;
      logic       muldiv_en;
      logic       is_branch;
      logic       is_jal;
      logic       is_jalr;
      logic       illegal;
      logic       is_load;
      logic       is_store;
   } decode_bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Upstream/downstream handshake and decoded-bundle bus of the decode stage.
// slave = the stage itself; master = the fetch/execute side driving it.
interface decode_stage_if;
   logic        up_valid_in;
   logic        up_ready_out;
   logic [31:0] instr_in;
   logic        dn_valid_out;
   logic        dn_ready_in;
   logic [1:0]  iadder_out_1_to_0_in;
   logic [3:0]  alu_opcode_out;
   logic [2:0]  imm_type_out;
   logic [2:0]  wb_mux_sel_out;
   logic [2:0]  csr_op_out;
   logic [2:0]  muldiv_op_out;
   logic [1:0]  load_size_out;
   logic        load_unsigned_out;
   logic        alu_src_out;
   logic        iadder_src_out;
   logic        rf_wr_en_out;
   logic        csr_wr_en_out;
   logic        muldiv_en_out;
   logic        is_branch_out;
   logic        is_jal_out;
   logic        is_jalr_out;
   logic        illegal_instr_out;
   logic        misaligned_load_out;
   logic        misaligned_store_out;
   logic        mem_wr_req_out;

   modport slave (
      input  up_valid_in, instr_in, dn_ready_in, iadder_out_1_to_0_in,
      output up_ready_out, dn_valid_out, alu_opcode_out, imm_type_out,
      output wb_mux_sel_out, csr_op_out, muldiv_op_out, load_size_out,
      output load_unsigned_out, alu_src_out, iadder_src_out, rf_wr_en_out,
      output csr_wr_en_out, muldiv_en_out, is_branch_out, is_jal_out,
      output is_jalr_out, illegal_instr_out, misaligned_load_out,
      output misaligned_store_out, mem_wr_req_out
   );

   modport master (
      output up_valid_in, instr_in, dn_ready_in, iadder_out_1_to_0_in,
      input  up_ready_out, dn_valid_out, alu_opcode_out, imm_type_out,
      input  wb_mux_sel_out, csr_op_out, muldiv_op_out, load_size_out,
      input  load_unsigned_out, alu_src_out, iadder_src_out, rf_wr_en_out,
      input  csr_wr_en_out, muldiv_en_out, is_branch_out, is_jal_out,
      input  is_jalr_out, illegal_instr_out, misaligned_load_out,
      input  misaligned_store_out, mem_wr_req_out
   );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32 instruction -> decoded bundle; zero latency, no flow control.
module decode_logic
   import decode_pkg::*;
#(
   parameter bit CSR_EN  = 1'b1,
   parameter bit MEXT_EN = 1'b0
) (
   input  logic [31:0]    instr,
   output decode_bundle_t bundle
);

   logic [4:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       unused_fields;

   assign opc = instr[6:2];
   assign f3  = instr[14:12];
   assign f7  = instr[31:25];
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   logic is_branch, is_jal, is_jalr, is_auipc, is_lui, is_op, is_op_imm;
   logic is_load, is_store, is_system, is_misc_mem, known_opc;
   logic csr, muldiv, op_imm_non_shift, op_f7_ok, illegal;

   assign is_branch   = (opc == OPC_BRANCH);
   assign is_jal      = (opc == OPC_JAL);
   assign is_jalr     = (opc == OPC_JALR);
   assign is_auipc    = (opc == OPC_AUIPC);
   assign is_lui      = (opc == OPC_LUI);
   assign is_op       = (opc == OPC_OP);
   assign is_op_imm   = (opc == OPC_OP_IMM);
   assign is_load     = (opc == OPC_LOAD);
   assign is_store    = (opc == OPC_STORE);
   assign is_system   = (opc == OPC_SYSTEM);
   assign is_misc_mem = (opc == OPC_MISC_MEM);
   assign known_opc   = is_branch | is_jal | is_jalr | is_auipc | is_lui | is_op |
                        is_op_imm | is_load | is_store | is_system | is_misc_mem;

   assign csr              = is_system & (f3 != 3'b000) & CSR_EN;
   assign muldiv           = is_op & (f7 == F7_MULDIV) & MEXT_EN;
   assign op_imm_non_shift = is_op_imm & (f3 != 3'b001) & (f3 != 3'b101);
   assign op_f7_ok         = (f7 == F7_BASE) | (f7 == F7_ALT) | (MEXT_EN & (f7 == F7_MULDIV));

   assign illegal = (instr[1:0] != 2'b11) | ~known_opc |
                    (is_system & (f3 != 3'b000) & ~CSR_EN) |
                    (is_op & ~op_f7_ok);

   always_comb begin
      bundle               = '0;
      bundle.alu_opcode    = {f7[5] & ~op_imm_non_shift, f3};
      bundle.imm_type      = {is_lui | is_auipc | is_jal | csr,
                              is_branch | is_store | csr,
                              is_op_imm | is_load | is_jal | is_jalr | is_branch};
      bundle.wb_mux_sel    = {csr | is_jal | is_jalr,
                              is_lui | is_auipc,
                              is_load | is_auipc | is_jalr | is_jal};
      bundle.csr_op        = csr ? f3 : 3'b000;
      bundle.muldiv_op     = muldiv ? f3 : 3'b000;
      bundle.load_size     = f3[1:0];
      bundle.load_unsigned = f3[2];
      bundle.alu_src       = instr[5];
      bundle.iadder_src    = is_load | is_store | is_jalr;
      // Illegal encodings must never write state or touch memory.
      bundle.rf_wr_en      = ~illegal & (is_lui | is_auipc | is_jal | is_jalr | is_op |
                                         is_op_imm | is_load | csr);
      bundle.csr_wr_en     = ~illegal & csr;
      bundle.muldiv_en     = ~illegal & muldiv;
      bundle.is_branch     = is_branch;
      bundle.is_jal        = is_jal;
      bundle.is_jalr       = is_jalr;
      bundle.illegal       = illegal;
      bundle.is_load       = ~illegal & is_load;
      bundle.is_store      = ~illegal & is_store;
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with head+skid buffer; 1-cycle latency, FIFO order.
// Backpressure: up_ready_out is ~skid_valid (registered); flush kills both entries.
module decode_stage
   import decode_pkg::*;
#(
   parameter bit CSR_EN       = 1'b1,
   parameter bit MEXT_EN      = 1'b0,
   parameter bit MISALIGN_CHK = 1'b1
) (
   input  logic           clk_in,
   input  logic           rst_n_in,
   input  logic           flush_in,
   input  logic           trap_taken_in,
   decode_stage_if.slave  bus
);

   decode_bundle_t dec_bundle;
   decode_bundle_t head_q, skid_q;
   logic           head_vld, skid_vld;
   logic           accept, drain;

   decode_logic #(
      .CSR_EN  (CSR_EN),
      .MEXT_EN (MEXT_EN)
   ) u_decode_logic (
      .instr  (bus.instr_in),
      .bundle (dec_bundle)
   );

   assign bus.up_ready_out = ~skid_vld;
   assign accept = bus.up_valid_in & ~skid_vld;
   assign drain  = head_vld & bus.dn_ready_in;

   // Accept is only possible with skid empty, so skid never needs to refill while moving.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head_vld <= 1'b0;
         skid_vld <= 1'b0;
         head_q   <= '0;
         skid_q   <= '0;
      end else if (flush_in) begin
         head_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else if (drain || !head_vld) begin
         if (skid_vld) begin
            head_q   <= skid_q;
            head_vld <= 1'b1;
            skid_vld <= 1'b0;
         end else if (accept) begin
            head_q   <= dec_bundle;
            head_vld <= 1'b1;
         end else begin
            head_vld <= 1'b0;
         end
      end else if (accept) begin
         skid_q   <= dec_bundle;
         skid_vld <= 1'b1;
      end
   end

   logic [1:0] lsbs;
   logic       lsb_bad, chk_en, mis_load, mis_store;

   assign lsbs = bus.iadder_out_1_to_0_in;

   always_comb begin
      lsb_bad = 1'b0;
      case (head_q.load_size)
         SIZE_WORD: lsb_bad = (lsbs != 2'b00);
         SIZE_HALF: lsb_bad = lsbs[0];
         default:   lsb_bad = 1'b0;
      endcase
   end

   assign chk_en    = head_vld & MISALIGN_CHK;
   assign mis_load  = chk_en & head_q.is_load & lsb_bad;
   assign mis_store = chk_en & head_q.is_store & lsb_bad;

   assign bus.dn_valid_out         = head_vld;
   assign bus.alu_opcode_out       = head_q.alu_opcode;
   assign bus.imm_type_out         = head_q.imm_type;
   assign bus.wb_mux_sel_out       = head_q.wb_mux_sel;
   assign bus.csr_op_out           = head_q.csr_op;
   assign bus.muldiv_op_out        = head_q.muldiv_op;
   assign bus.load_size_out        = head_q.load_size;
   assign bus.load_unsigned_out    = head_q.load_unsigned;
   assign bus.alu_src_out          = head_q.alu_src;
   assign bus.iadder_src_out       = head_q.iadder_src;
   assign bus.rf_wr_en_out         = head_q.rf_wr_en;
   assign bus.csr_wr_en_out        = head_q.csr_wr_en;
   assign bus.muldiv_en_out        = head_q.muldiv_en;
   assign bus.is_branch_out        = head_q.is_branch;
   assign bus.is_jal_out           = head_q.is_jal;
   assign bus.is_jalr_out          = head_q.is_jalr;
   assign bus.illegal_instr_out    = head_q.illegal;
   assign bus.misaligned_load_out  = mis_load;
   assign bus.misaligned_store_out = mis_store;
   assign bus.mem_wr_req_out       = head_vld & head_q.is_store & ~mis_store &
                                     ~trap_taken_in & ~flush_in;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default build plus a CSR_EN=0/MEXT_EN=1 build.
module tb_decode_stage;

   logic clk_in = 1'b0;
   logic rst_n_in, flush_in, trap_taken_in;
   int   errors = 0;
   int   checks = 0;

   always #5 clk_in = ~clk_in;

   decode_stage_if ifa ();
   decode_stage_if ifb ();

   assign ifb.up_valid_in          = ifa.up_valid_in;
   assign ifb.instr_in             = ifa.instr_in;
   assign ifb.dn_ready_in          = ifa.dn_ready_in;
   assign ifb.iadder_out_1_to_0_in = ifa.iadder_out_1_to_0_in;

   decode_stage #(.CSR_EN(1'b1), .MEXT_EN(1'b0), .MISALIGN_CHK(1'b1)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
      .trap_taken_in(trap_taken_in), .bus(ifa.slave)
   );

   decode_stage #(.CSR_EN(1'b0), .MEXT_EN(1'b1), .MISALIGN_CHK(1'b1)) dut_b (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
      .trap_taken_in(trap_taken_in), .bus(ifb.slave)
   );

   localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
   localparam logic [31:0] I_ADDI1 = 32'h00100113; // addi x2,x0,1
   localparam logic [31:0] I_LUI   = 32'h123451B7; // lui x3,0x12345
   localparam logic [31:0] I_JAL   = 32'h000000EF; // jal x1,0
   localparam logic [31:0] I_SW    = 32'h00202023; // sw x2,0(x0)
   localparam logic [31:0] I_LH    = 32'h00001083; // lh x1,0(x0)
   localparam logic [31:0] I_CSRRW = 32'h34011073;
   localparam logic [31:0] I_MUL   = 32'h02208033;
   localparam logic [31:0] I_BADLO = 32'h00500090; // opcode[1:0]=00

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] ins);
      ifa.up_valid_in = 1'b1;
      ifa.instr_in    = ins;
      @(posedge clk_in); #1;
      ifa.up_valid_in = 1'b0;
   endtask

   task automatic drain_one();
      ifa.dn_ready_in = 1'b1;
      @(posedge clk_in); #1;
      ifa.dn_ready_in = 1'b0;
   endtask

   initial begin
      rst_n_in = 1'b0; flush_in = 1'b0; trap_taken_in = 1'b0;
      ifa.up_valid_in = 1'b0; ifa.instr_in = 32'h0; ifa.dn_ready_in = 1'b0;
      ifa.iadder_out_1_to_0_in = 2'b00;
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_dn_valid", 32'(ifa.dn_valid_out), 32'd0);
      chk("rst_up_ready", 32'(ifa.up_ready_out), 32'd1);
      chk("rst_alu_op",   32'(ifa.alu_opcode_out), 32'd0);
      chk("rst_rf_wr",    32'(ifa.rf_wr_en_out), 32'd0);
      rst_n_in = 1'b1;
      @(posedge clk_in); #1;

      // addi with execute ready: visible one cycle after accept
      ifa.dn_ready_in = 1'b1;
      send(I_ADDI);
      chk("addi_valid",   32'(ifa.dn_valid_out), 32'd1);
      chk("addi_rf_wr",   32'(ifa.rf_wr_en_out), 32'd1);
      chk("addi_imm",     32'(ifa.imm_type_out), 32'd1);
      chk("addi_wb",      32'(ifa.wb_mux_sel_out), 32'd0);
      chk("addi_alu_op",  32'(ifa.alu_opcode_out), 32'd0);
      chk("addi_illegal", 32'(ifa.illegal_instr_out), 32'd0);
      @(posedge clk_in); #1;
      chk("addi_drained", 32'(ifa.dn_valid_out), 32'd0);

      // three-deep stream against a stalled execute stage
      ifa.dn_ready_in = 1'b0;
      send(I_ADDI1);
      chk("str_rdy1", 32'(ifa.up_ready_out), 32'd1);
      send(I_LUI);
      chk("str_rdy2", 32'(ifa.up_ready_out), 32'd0);
      ifa.up_valid_in = 1'b1; ifa.instr_in = I_JAL;
      @(posedge clk_in); #1;
      chk("str_hold_rdy", 32'(ifa.up_ready_out), 32'd0);
      chk("str_hold_wb",  32'(ifa.wb_mux_sel_out), 32'd0);
      chk("str_hold_imm", 32'(ifa.imm_type_out), 32'd1);
      ifa.dn_ready_in = 1'b1;
      @(posedge clk_in); #1;
      chk("str_b2_valid", 32'(ifa.dn_valid_out), 32'd1);
      chk("str_b2_wb",    32'(ifa.wb_mux_sel_out), 32'd2);
      chk("str_b2_imm",   32'(ifa.imm_type_out), 32'd4);
      chk("str_b2_rdy",   32'(ifa.up_ready_out), 32'd1);
      @(posedge clk_in); #1;
      ifa.up_valid_in = 1'b0;
      chk("str_b3_valid", 32'(ifa.dn_valid_out), 32'd1);
      chk("str_b3_wb",    32'(ifa.wb_mux_sel_out), 32'd5);
      chk("str_b3_jal",   32'(ifa.is_jal_out), 32'd1);
      @(posedge clk_in); #1;
      chk("str_empty", 32'(ifa.dn_valid_out), 32'd0);
      ifa.dn_ready_in = 1'b0;

      // store: misalignment, trap and flush suppression
      send(I_SW);
      ifa.iadder_out_1_to_0_in = 2'b10; #1;
      chk("sw10_mis",  32'(ifa.misaligned_store_out), 32'd1);
      chk("sw10_req",  32'(ifa.mem_wr_req_out), 32'd0);
      chk("sw_imm",    32'(ifa.imm_type_out), 32'd2);
      chk("sw_rf_wr",  32'(ifa.rf_wr_en_out), 32'd0);
      ifa.iadder_out_1_to_0_in = 2'b00; trap_taken_in = 1'b1; #1;
      chk("sw_trap_mis", 32'(ifa.misaligned_store_out), 32'd0);
      chk("sw_trap_req", 32'(ifa.mem_wr_req_out), 32'd0);
      trap_taken_in = 1'b0; #1;
      chk("sw_ok_req", 32'(ifa.mem_wr_req_out), 32'd1);
      ifa.iadder_out_1_to_0_in = 2'b01; #1;
      chk("sw01_mis", 32'(ifa.misaligned_store_out), 32'd1);
      chk("sw01_req", 32'(ifa.mem_wr_req_out), 32'd0);
      ifa.iadder_out_1_to_0_in = 2'b00; flush_in = 1'b1; #1;
      chk("sw_flush_req", 32'(ifa.mem_wr_req_out), 32'd0);
      @(posedge clk_in); #1;
      flush_in = 1'b0;
      chk("sw_flushed", 32'(ifa.dn_valid_out), 32'd0);

      // halfword load
      send(I_LH);
      ifa.iadder_out_1_to_0_in = 2'b01; #1;
      chk("lh01_mis",   32'(ifa.misaligned_load_out), 32'd1);
      chk("lh_mis_st",  32'(ifa.misaligned_store_out), 32'd0);
      chk("lh_size",    32'(ifa.load_size_out), 32'd1);
      chk("lh_wb",      32'(ifa.wb_mux_sel_out), 32'd1);
      chk("lh_iadd",    32'(ifa.iadder_src_out), 32'd1);
      chk("lh_req",     32'(ifa.mem_wr_req_out), 32'd0);
      ifa.iadder_out_1_to_0_in = 2'b10; #1;
      chk("lh10_mis",   32'(ifa.misaligned_load_out), 32'd0);
      ifa.iadder_out_1_to_0_in = 2'b00;
      drain_one();

      // csrrw in both builds
      send(I_CSRRW);
      chk("csr_wr_en",   32'(ifa.csr_wr_en_out), 32'd1);
      chk("csr_op",      32'(ifa.csr_op_out), 32'd1);
      chk("csr_wb",      32'(ifa.wb_mux_sel_out), 32'd4);
      chk("csr_imm",     32'(ifa.imm_type_out), 32'd6);
      chk("csr_illegal", 32'(ifa.illegal_instr_out), 32'd0);
      chk("nocsr_illegal", 32'(ifb.illegal_instr_out), 32'd1);
      chk("nocsr_rf_wr",   32'(ifb.rf_wr_en_out), 32'd0);
      chk("nocsr_wr_en",   32'(ifb.csr_wr_en_out), 32'd0);
      drain_one();

      // mul in both builds
      send(I_MUL);
      chk("nom_illegal", 32'(ifa.illegal_instr_out), 32'd1);
      chk("nom_en",      32'(ifa.muldiv_en_out), 32'd0);
      chk("nom_rf_wr",   32'(ifa.rf_wr_en_out), 32'd0);
      chk("mul_en",      32'(ifb.muldiv_en_out), 32'd1);
      chk("mul_op",      32'(ifb.muldiv_op_out), 32'd0);
      chk("mul_illegal", 32'(ifb.illegal_instr_out), 32'd0);
      chk("mul_rf_wr",   32'(ifb.rf_wr_en_out), 32'd1);
      drain_one();

      send(I_BADLO);
      chk("badlo_illegal", 32'(ifa.illegal_instr_out), 32'd1);
      chk("badlo_rf_wr",   32'(ifa.rf_wr_en_out), 32'd0);
      drain_one();

      // flush with both entries full and a pending upstream instruction
      send(I_ADDI1);
      send(I_LUI);
      chk("fl_full_rdy", 32'(ifa.up_ready_out), 32'd0);
      ifa.up_valid_in = 1'b1; ifa.instr_in = I_JAL; flush_in = 1'b1;
      @(posedge clk_in); #1;
      flush_in = 1'b0; ifa.up_valid_in = 1'b0;
      chk("fl_valid", 32'(ifa.dn_valid_out), 32'd0);
      chk("fl_rdy",   32'(ifa.up_ready_out), 32'd1);
      // flush while stage is ready: the accepted-looking instr must vanish
      send(I_ADDI1);
      ifa.up_valid_in = 1'b1; ifa.instr_in = I_LUI; flush_in = 1'b1;
      @(posedge clk_in); #1;
      flush_in = 1'b0; ifa.up_valid_in = 1'b0;
      chk("fl2_valid", 32'(ifa.dn_valid_out), 32'd0);
      @(posedge clk_in); #1;
      chk("fl2_absent", 32'(ifa.dn_valid_out), 32'd0);

      // asynchronous reset mid-cycle
      send(I_JAL);
      chk("ar_pre_valid", 32'(ifa.dn_valid_out), 32'd1);
      #2 rst_n_in = 1'b0;
      #1;
      chk("ar_valid", 32'(ifa.dn_valid_out), 32'd0);
      chk("ar_rdy",   32'(ifa.up_ready_out), 32'd1);
      chk("ar_wb",    32'(ifa.wb_mux_sel_out), 32'd0);
      @(posedge clk_in); #1;
      rst_n_in = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
